uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: serialises one start bit, 7 or 8 data bits (LSB first),
// an optional parity bit and 1 or 2 stop bits. Bit timing comes from an
// external baud clock (clk_uart) whose falling edges mark bit boundaries.
module uart_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_uart,
  output logic       uart_enable,
  output logic       tx,
  input  logic       data_size,
  input  logic       parity_en,
  input  logic [1:0] parity_mode,
  input  logic       stop_bit_size,
  input  logic [7:0] data,
  output logic       ready,
  input  logic       send
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [1:0] PAR_ODD   = 2'b11;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_MARK  = 2'b01;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t              state_q,      state_d;
  logic                clk_uart_d_q, clk_uart_d_d;
  logic [DATA_W-1:0]   shift_q,      shift_d;
  logic [CNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
  logic                size_q,       size_d;
  logic                par_en_q,     par_en_d;
  logic                stop2_q,      stop2_d;
  logic                par_bit_q,    par_bit_d;
  logic                tx_q,         tx_d;
  logic                ready_q,      ready_d;
  logic                enable_q,     enable_d;

  logic                tick_c;
  logic [CNT_W-1:0]    last_bit_c;
  logic [DATA_W-1:0]   data_masked_c;
  logic                data_xor_c;
  logic                par_new_c;

  // Baud tick: falling edge of clk_uart, acted on in the same cycle.
  assign tick_c = clk_uart_d_q & ~clk_uart;

  // Index of the final data bit for the latched frame width.
  assign last_bit_c = size_q ? CNT_W'(7) : CNT_W'(6);

  // Parity of the incoming byte, computed once at latch time so the data
  // register is free to shift.
  always_comb begin
    data_masked_c = data_size ? data : {1'b0, data[6:0]};
    data_xor_c    = ^data_masked_c;
    unique case (parity_mode)
      PAR_ODD:  par_new_c = ~data_xor_c;
      PAR_EVEN: par_new_c = data_xor_c;
      PAR_MARK: par_new_c = 1'b1;
      default:  par_new_c = 1'b0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    clk_uart_d_d = clk_uart;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    size_d       = size_q;
    par_en_d     = par_en_q;
    stop2_d      = stop2_q;
    par_bit_d    = par_bit_q;
    tx_d         = tx_q;
    ready_d      = ready_q;
    enable_d     = enable_q;

    unique case (state_q)
      IDLE: begin
        tx_d     = 1'b1;
        ready_d  = 1'b1;
        enable_d = 1'b0;
        if (send) begin
          state_d   = START;
          shift_d   = data_masked_c;
          bit_cnt_d = '0;
          size_d    = data_size;
          par_en_d  = parity_en;
          stop2_d   = stop_bit_size;
          par_bit_d = par_new_c;
          tx_d      = 1'b0;
          ready_d   = 1'b0;
          enable_d  = 1'b1;
        end
      end

      START: begin
        if (tick_c) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end

      DATA: begin
        if (tick_c) begin
          if (bit_cnt_q == last_bit_c) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP1;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      PARITY: begin
        if (tick_c) begin
          state_d = STOP1;
          tx_d    = 1'b1;
        end
      end

      STOP1: begin
        if (tick_c) begin
          tx_d = 1'b1;
          if (stop2_q) begin
            state_d = STOP2;
          end else begin
            state_d  = IDLE;
            ready_d  = 1'b1;
            enable_d = 1'b0;
          end
        end
      end

      STOP2: begin
        if (tick_c) begin
          state_d  = IDLE;
          tx_d     = 1'b1;
          ready_d  = 1'b1;
          enable_d = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        tx_d     = 1'b1;
        ready_d  = 1'b1;
        enable_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_uart_d_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      size_q       <= 1'b0;
      par_en_q     <= 1'b0;
      stop2_q      <= 1'b0;
      par_bit_q    <= 1'b0;
      tx_q         <= 1'b1;
      ready_q      <= 1'b1;
      enable_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_uart_d_q <= clk_uart_d_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      size_q       <= size_d;
      par_en_q     <= par_en_d;
      stop2_q      <= stop2_d;
      par_bit_q    <= par_bit_d;
      tx_q         <= tx_d;
      ready_q      <= ready_d;
      enable_q     <= enable_d;
    end
  end

  assign tx          = tx_q;
  assign ready       = ready_q;
  assign uart_enable = enable_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a behavioural baud generator and a
// bit-level scoreboard sampled mid-bit.
module tb_uart_tx;

  localparam int P = 16;  // clk cycles per bit period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_uart = 1'b0;
  logic       uart_enable;
  logic       tx;
  logic       data_size = 1'b1;
  logic       parity_en = 1'b0;
  logic [1:0] parity_mode = 2'b00;
  logic       stop_bit_size = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready;
  logic       send = 1'b0;

  int checks = 0;
  int errors = 0;
  int ucnt = 0;
  int en_cnt = 0;
  int cyc = 0;
  bit sb[$];
  bit obs_q[$];

  uart_tx dut (
    .clk          (clk),
    .rst          (rst),
    .clk_uart     (clk_uart),
    .uart_enable  (uart_enable),
    .tx           (tx),
    .data_size    (data_size),
    .parity_en    (parity_en),
    .parity_mode  (parity_mode),
    .stop_bit_size(stop_bit_size),
    .data         (data),
    .ready        (ready),
    .send         (send)
  );

  always #5 clk = ~clk;

  // Baud generator model plus mid-bit sampler of tx.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (uart_enable !== 1'b1) begin
      ucnt     = 0;
      clk_uart = 1'b0;
    end else begin
      ucnt   = ucnt + 1;
      en_cnt = en_cnt + 1;
      if ((ucnt % P) == P / 2) obs_q.push_back(tx);
      clk_uart = ((ucnt % P) >= P / 2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bit sequence for one frame.
  task automatic push_frame(input logic [7:0] d, input logic sz, input logic pe,
                            input logic [1:0] pm, input logic s2);
    int  n;
    bit  p;
    n = sz ? 8 : 7;
    p = 1'b0;
    sb.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      sb.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe) begin
      case (pm)
        2'b11:   sb.push_back(~p);
        2'b10:   sb.push_back(p);
        2'b01:   sb.push_back(1'b1);
        default: sb.push_back(1'b0);
      endcase
    end
    sb.push_back(1'b1);
    if (s2) sb.push_back(1'b1);
  endtask

  task automatic compare_bits(input string tag);
    int i;
    chk({tag, "_nbits"}, 32'(obs_q.size()), 32'(sb.size()));
    i = 0;
    while (sb.size() > 0 && obs_q.size() > 0) begin
      chk($sformatf("%s_bit%0d", tag, i), 32'(obs_q.pop_front()), 32'(sb.pop_front()));
      i++;
    end
    sb.delete();
    obs_q.delete();
  endtask

  // Wait for ready or uart_enable to reach a level within a cycle budget.
  task automatic wait_sig(input bit use_ready, input logic val, input int budget,
                          input string tag);
    int  n;
    logic s;
    n = 0;
    s = use_ready ? ready : uart_enable;
    while (s !== val && n < budget) begin
      @(negedge clk);
      n++;
      s = use_ready ? ready : uart_enable;
    end
    chk({tag, "_timeout"}, 32'(s === val), 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic sz, input logic pe,
                           input logic [1:0] pm, input logic s2, input bit scramble,
                           input string tag);
    int nbits;
    int e0;
    int len;
    @(negedge clk);
    rst = 1'b0;
    data = d; data_size = sz; parity_en = pe; parity_mode = pm; stop_bit_size = s2;
    send = 1'b1;
    push_frame(d, sz, pe, pm, s2);
    nbits = sb.size();
    e0 = en_cnt;
    @(negedge clk);
    chk({tag, "_start_ready"}, 32'(ready), 32'd0);
    chk({tag, "_start_en"}, 32'(uart_enable), 32'd1);
    chk({tag, "_start_tx"}, 32'(tx), 32'd0);
    send = 1'b0;
    if (scramble) begin
      repeat (3 * P) @(negedge clk);
      data = ~d; data_size = ~sz; parity_en = ~pe; parity_mode = ~pm; stop_bit_size = ~s2;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
    end
    wait_sig(1'b0, 1'b0, 14 * P, tag);
    chk({tag, "_end_ready"}, 32'(ready), 32'd1);
    chk({tag, "_end_tx"}, 32'(tx), 32'd1);
    len = en_cnt - e0;
    chk({tag, "_length"}, 32'(len >= nbits * P - 1 && len <= nbits * P + 1), 32'd1);
    compare_bits(tag);
    repeat (3) @(negedge clk);
    chk({tag, "_stays_idle"}, 32'(uart_enable), 32'd0);
  endtask

  initial begin
    int t0;
    int el;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_en", 32'(uart_enable), 32'd0);

    run_frame(8'h55, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "f8n1_55");
    run_frame(8'hC1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, "f7e1_c1");
    run_frame(8'h03, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, "f8o2_03");
    run_frame(8'h00, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, "mark_00");
    run_frame(8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, "space_00");
    run_frame(8'hA7, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, "scramble_a7");
    run_frame(8'h6B, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, "scramble_6b");

    // Mid-frame reset during data bit 3
    @(negedge clk);
    data = 8'h5A; data_size = 1'b1; parity_en = 1'b0; parity_mode = 2'b00;
    stop_bit_size = 1'b0; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    begin
      int n;
      n = 0;
      while (ucnt < 4 * P + P / 2 && n < 10 * P) begin
        @(negedge clk);
        n++;
      end
      chk("midrst_reach_bit3", 32'(ucnt >= 4 * P + P / 2), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_en", 32'(uart_enable), 32'd0);
    sb.delete();
    obs_q.delete();
    run_frame(8'h96, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, "after_rst_96");

    // Back-to-back frames with send held high
    @(negedge clk);
    data = 8'h00; data_size = 1'b1; parity_en = 1'b0; parity_mode = 2'b00;
    stop_bit_size = 1'b0; send = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 16; i++) push_frame(8'(i), 1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      wait_sig(1'b1, 1'b0, 4, $sformatf("b2b_start%0d", i));
      if (i < 15) data = 8'(i + 1);
      else send = 1'b0;
      wait_sig(1'b1, 1'b1, 12 * P, $sformatf("b2b_end%0d", i));
    end
    el = cyc - t0;
    chk("b2b_contiguous", 32'(el >= 160 * P - 16 && el <= 160 * P + 48), 32'd1);
    compare_bits("b2b");
    repeat (2) @(negedge clk);
    chk("b2b_idle_en", 32'(uart_enable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
